// File: rtl/axil_reg_bank_pkg.sv
// Shared AXI-Lite definitions for the register bank: response codes,
// write/read FSM state encodings and the address-to-response decoder.
package axil_reg_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

    // Control words are OKAY both ways; status words reject writes;
    // anything past the status block is unmapped.
    function automatic logic [1:0] decode_resp(
        input logic [29:0]  widx,
        input int unsigned  num_rw,
        input int unsigned  num_ro,
        input logic         is_write
    );
        if ({2'b00, widx} < num_rw) begin
            return RESP_OKAY;
        end else if ({2'b00, widx} < num_rw + num_ro) begin
            return is_write ? RESP_SLVERR : RESP_OKAY;
        end else begin
            return RESP_DECERR;
        end
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle, 32-bit address and data.
// valid/ready: a beat transfers on a cycle where both are high; the sender
// keeps valid and payload stable until then, and ready may not wait on valid
// being low.
interface AXIL_IF;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport Slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_write_join.sv
// Joins the AW and W channels in either order, issues a one-cycle commit when
// both halves are present, and holds the B response until bready.
module axil_write_join
    import axil_reg_bank_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] awidx,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [1:0]  commit_resp,
    output logic        commit,
    output logic [29:0] commit_idx,
    output logic [31:0] commit_data,
    output logic [3:0]  commit_strb,
    output w_state_e    state
);

    w_state_e    next_state;
    logic        live;
    logic        aw_hs;
    logic        w_hs;
    logic [29:0] aw_idx_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    // Keeps the ready outputs low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    assign awready = live && (state == W_IDLE || state == W_HAVE_W);
    assign wready  = live && (state == W_IDLE || state == W_HAVE_AW);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= W_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            W_IDLE: begin
                if (aw_hs && w_hs) next_state = W_RESP;
                else if (aw_hs)    next_state = W_HAVE_AW;
                else if (w_hs)     next_state = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)   next_state = W_RESP;
            W_HAVE_W:  if (aw_hs)  next_state = W_RESP;
            W_RESP:    if (bready) next_state = W_IDLE;
            default:               next_state = W_IDLE;
        endcase
    end

    // The commit takes whichever half is still on the bus this cycle.
    always_comb begin
        bvalid      = (state == W_RESP);
        commit      = (state == W_IDLE && aw_hs && w_hs)
                   || (state == W_HAVE_AW && w_hs)
                   || (state == W_HAVE_W && aw_hs);
        commit_idx  = (state == W_HAVE_AW) ? aw_idx_q : awidx;
        commit_data = (state == W_HAVE_W)  ? w_data_q : wdata;
        commit_strb = (state == W_HAVE_W)  ? w_strb_q : wstrb;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp    <= RESP_OKAY;
        end else begin
            if (aw_hs)  aw_idx_q <= awidx;
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) bresp <= commit_resp;
        end
    end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI-Lite register bank: NUM_RW byte-writable control words followed by
// NUM_RO read-only status words sampled when the read address is accepted.
module axil_reg_bank
    import axil_reg_bank_pkg::*;
#(
    parameter int unsigned                   NUM_RW   = 8,
    parameter int unsigned                   NUM_RO   = 8,
    parameter logic [NUM_RW-1:0][31:0]       RW_RESET = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    AXIL_IF.Slave                    axil_if,
    output logic [NUM_RW-1:0][31:0]  ctrl_out,
    output logic [NUM_RW-1:0]        ctrl_wr_pulse,
    input  logic [NUM_RO-1:0][31:0]  status_in,
    output w_state_e                 w_state,
    output r_state_e                 r_state
);

    logic        commit;
    logic [29:0] commit_idx;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;
    logic [1:0]  commit_resp;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{axil_if.awaddr[1:0], axil_if.araddr[1:0]};
    assign commit_resp      = decode_resp(commit_idx, NUM_RW, NUM_RO, 1'b1);

    axil_write_join u_write_join (
        .clk         (clk),
        .reset_n     (reset_n),
        .awidx       (axil_if.awaddr[31:2]),
        .awvalid     (axil_if.awvalid),
        .awready     (axil_if.awready),
        .wdata       (axil_if.wdata),
        .wstrb       (axil_if.wstrb),
        .wvalid      (axil_if.wvalid),
        .wready      (axil_if.wready),
        .bresp       (axil_if.bresp),
        .bvalid      (axil_if.bvalid),
        .bready      (axil_if.bready),
        .commit_resp (commit_resp),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .state       (w_state)
    );

    // Status and unmapped indices never match here, so they leave no trace.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_out      <= RW_RESET;
            ctrl_wr_pulse <= '0;
        end else begin
            ctrl_wr_pulse <= '0;
            if (commit) begin
                for (int i = 0; i < int'(NUM_RW); i++) begin
                    if (commit_idx == 30'(i)) begin
                        ctrl_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (commit_strb[b]) ctrl_out[i][8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    r_state_e    r_next;
    logic        r_live;
    logic        arready;
    logic        rvalid;
    logic        ar_hs;
    logic [29:0] rd_idx;
    logic [31:0] rd_word;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)           r_next = R_RESP;
            R_RESP:  if (axil_if.rready)  r_next = R_IDLE;
            default:                      r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = r_live && (r_state == R_IDLE);
        rvalid  = (r_state == R_RESP);
    end

    assign ar_hs  = axil_if.arvalid && arready;
    assign rd_idx = axil_if.araddr[31:2];

    // Unmapped reads fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(NUM_RW); i++) begin
            if (rd_idx == 30'(i)) rd_word = ctrl_out[i];
        end
        for (int i = 0; i < int'(NUM_RO); i++) begin
            if (rd_idx == 30'(int'(NUM_RW) + i)) rd_word = status_in[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= decode_resp(rd_idx, NUM_RW, NUM_RO, 1'b0);
        end
    end

    assign axil_if.arready = arready;
    assign axil_if.rvalid  = rvalid;
    assign axil_if.rdata   = rdata_q;
    assign axil_if.rresp   = rresp_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: a vector table of single transactions
// plus hand-timed sequences for ordering, back-pressure and reset cases.
module tb_axil_reg_bank;
    import axil_reg_bank_pkg::*;

    localparam int NRW = 8;
    localparam int NRO = 8;
    localparam logic [NRW-1:0][31:0] RST_VALS = {32'h0, 32'h0, 32'h0, 32'h0,
                                                 32'h0, 32'h11, 32'h0, 32'h12345678};

    logic                  clk;
    logic                  reset_n;
    logic [NRW-1:0][31:0]  ctrl_out;
    logic [NRW-1:0]        ctrl_wr_pulse;
    logic [NRO-1:0][31:0]  status_in;
    w_state_e              w_state;
    r_state_e              r_state;

    AXIL_IF bus ();

    axil_reg_bank #(.NUM_RW(NRW), .NUM_RO(NRO), .RW_RESET(RST_VALS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .axil_if       (bus),
        .ctrl_out      (ctrl_out),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .status_in     (status_in),
        .w_state       (w_state),
        .r_state       (r_state)
    );

    int vec_count  = 0;
    int miss_count = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;   // read data, or expected ctrl_wr_pulse for a write
    } vec_t;
    vec_t vecs[11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vec_count++;
        miss_count++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic wr_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [7:0] pulse);
        bit aw_done, w_done, af, wf, got;
        int n;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        resp = 2'bxx; pulse = 8'hxx;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            af = bus.awvalid && bus.awready;
            wf = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (af) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (wf) begin bus.wvalid = 1'b0;  w_done = 1;  end
            n++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!(aw_done && w_done)) timeout("wr_addr_data");
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (bus.bvalid) begin
                got = 1; resp = bus.bresp; pulse = ctrl_wr_pulse;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.bready = 1'b0;
        if (!got) timeout("wr_bresp");
    endtask

    task automatic rd_txn(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit done, got;
        int n;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        done = 0; n = 0;
        data = 'x; resp = 'x;
        while (!done && n < 20) begin
            @(negedge clk);
            done = bus.arready;
            @(posedge clk); #1;
            n++;
        end
        bus.arvalid = 1'b0;
        if (!done) timeout("rd_addr");
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (bus.rvalid) begin
                got = 1; data = bus.rdata; resp = bus.rresp;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.rready = 1'b0;
        if (!got) timeout("rd_data");
    endtask

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pulse;
        logic [31:0] data;
        logic [31:0] exp;

        vecs[0]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, RESP_SLVERR, 32'h00};
        vecs[1]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, RESP_DECERR, 32'h00};
        vecs[2]  = '{1'b0, 32'h40, 32'h0,        4'h0, RESP_DECERR, 32'h0};
        vecs[3]  = '{1'b1, 32'h1C, 32'h55AA00FF, 4'h5, RESP_OKAY,   32'h80};
        vecs[4]  = '{1'b0, 32'h1C, 32'h0,        4'h0, RESP_OKAY,   32'h00AA00FF};
        vecs[5]  = '{1'b1, 32'h07, 32'h01020304, 4'h8, RESP_OKAY,   32'h02};
        vecs[6]  = '{1'b0, 32'h05, 32'h0,        4'h0, RESP_OKAY,   32'h01ADBEEF};
        vecs[7]  = '{1'b0, 32'h3C, 32'h0,        4'h0, RESP_OKAY,   32'h77770007};
        vecs[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, RESP_OKAY,   32'h1234ABCD};
        vecs[9]  = '{1'b1, 32'h3C, 32'h0000FFFF, 4'hF, RESP_SLVERR, 32'h00};
        vecs[10] = '{1'b0, 32'h44, 32'h0,        4'h0, RESP_DECERR, 32'h0};

        for (int i = 0; i < NRO; i++) status_in[i] = 32'h77770000 | 32'(i);
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        reset_n = 1'b0;

        // Reset values and ready release timing
        repeat (2) @(negedge clk);
        check("rst_readies", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h0);
        check("rst_valids", {30'b0, bus.bvalid, bus.rvalid}, 32'h0);
        check("rst_pulse", 32'(ctrl_wr_pulse), 32'h0);
        check("rst_ctrl0", ctrl_out[0], 32'h12345678);
        check("rst_ctrl2", ctrl_out[2], 32'h11);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_fsms", {30'b0, 1'(w_state == W_IDLE), 1'(r_state == R_IDLE)}, 32'h3);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("rel_not_ready", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h0);
        @(negedge clk);
        check("rel_ready", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);

        // AW and W together, B held with bready low
        @(posedge clk); #1;
        bus.awaddr = 32'h04; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
        @(negedge clk);
        check("s28_accept", {30'b0, bus.awready, bus.wready}, 32'h3);
        @(posedge clk); #1 bus.awvalid = 0; bus.wvalid = 0;
        @(negedge clk);
        check("s28_bvalid", 32'(bus.bvalid), 32'h1);
        check("s28_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
        check("s28_pulse", 32'(ctrl_wr_pulse), 32'h02);
        check("s28_ctrl1", ctrl_out[1], 32'hDEADBEEF);
        check("s28_wstate", 32'(w_state), 32'(W_RESP));
        @(negedge clk);
        check("s28_pulse_off", 32'(ctrl_wr_pulse), 32'h0);
        check("s28_bhold", {30'b0, bus.bvalid, bus.awready}, 32'h2);
        @(posedge clk); #1 bus.bready = 1;
        @(posedge clk); #1 bus.bready = 0;
        @(negedge clk);
        check("s28_after_b", {29'b0, bus.bvalid, bus.awready, bus.wready}, 32'h3);

        // W three cycles ahead of AW, partial strobe
        @(posedge clk); #1;
        bus.wdata = 32'h0000ABCD; bus.wstrb = 4'h3; bus.wvalid = 1; bus.bready = 1;
        @(posedge clk); #1 bus.wvalid = 0;
        repeat (3) begin
            @(negedge clk);
            check("s29_w_held", {29'b0, bus.wready, bus.awready, bus.bvalid}, 32'h2);
            check("s29_wstate", 32'(w_state), 32'(W_HAVE_W));
        end
        check("s29_ctrl0_pre", ctrl_out[0], 32'h12345678);
        @(posedge clk); #1 bus.awaddr = 32'h00; bus.awvalid = 1;
        @(posedge clk); #1 bus.awvalid = 0;
        @(negedge clk);
        check("s29_bvalid", 32'(bus.bvalid), 32'h1);
        check("s29_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
        check("s29_ctrl0", ctrl_out[0], 32'h1234ABCD);
        check("s29_pulse", 32'(ctrl_wr_pulse), 32'h01);
        @(posedge clk); #1 bus.bready = 0;

        // Table of single transactions
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr) begin
                wr_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
                check($sformatf("vec%0d_pulse", i), 32'(pulse), vecs[i].exp);
            end else begin
                exp_q.push_back(vecs[i].exp);
                rd_txn(vecs[i].addr, data, resp);
                exp = exp_q.pop_front();
                check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), data, exp);
            end
        end

        // Status read held under rready low; status changes after sampling
        status_in[0] = 32'hCAFEF00D;
        @(posedge clk); #1 bus.araddr = 32'h20; bus.arvalid = 1; bus.rready = 0;
        @(negedge clk);
        check("s31_arready", 32'(bus.arready), 32'h1);
        @(posedge clk); #1 bus.arvalid = 0; status_in[0] = 32'h0BADBEEF;
        repeat (5) begin
            @(negedge clk);
            check("s31_hold", {bus.rvalid, bus.arready, 30'b0}, 32'h80000000);
            check("s31_rdata", bus.rdata, 32'hCAFEF00D);
        end
        @(posedge clk); #1 bus.rready = 1;
        @(negedge clk);
        check("s31_rresp", {30'b0, bus.rresp}, 32'(RESP_OKAY));
        @(posedge clk); #1 bus.rready = 0;
        @(negedge clk);
        check("s31_done", {30'b0, bus.rvalid, bus.arready}, 32'h1);

        // Read and write of the same control word on one edge
        @(posedge clk); #1;
        bus.araddr = 32'h08; bus.arvalid = 1; bus.rready = 0;
        bus.awaddr = 32'h08; bus.wdata = 32'h22; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
        @(negedge clk);
        check("s32_accept", {29'b0, bus.arready, bus.awready, bus.wready}, 32'h7);
        @(posedge clk); #1 bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
        @(negedge clk);
        check("s32_old_rdata", bus.rdata, 32'h11);
        check("s32_new_ctrl", ctrl_out[2], 32'h22);
        check("s32_both_valid", {30'b0, bus.rvalid, bus.bvalid}, 32'h3);
        @(posedge clk); #1 bus.rready = 1; bus.bready = 1;
        @(posedge clk); #1 bus.rready = 0; bus.bready = 0;
        rd_txn(32'h08, data, resp);
        check("s32_new_rdata", data, 32'h22);

        // Reset while a B response is pending
        @(posedge clk); #1;
        bus.awaddr = 32'h0C; bus.wdata = 32'h33333333; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
        @(posedge clk); #1 bus.awvalid = 0; bus.wvalid = 0;
        @(negedge clk);
        check("s33_pending", 32'(bus.bvalid), 32'h1);
        check("s33_ctrl3_written", ctrl_out[3], 32'h33333333);
        #1 reset_n = 1'b0;
        #1;
        check("s33_bvalid_drop", 32'(bus.bvalid), 32'h0);
        for (int i = 0; i < NRW; i++) check($sformatf("s33_ctrl%0d", i), ctrl_out[i], RST_VALS[i]);
        check("s33_wstate", 32'(w_state), 32'(W_IDLE));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; bus.bready = 1;
        @(negedge clk);
        check("s33_first_edge", {30'b0, bus.awready, bus.bvalid}, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("s33_no_resp", {30'b0, bus.bvalid, bus.rvalid}, 32'h0);
        end
        @(posedge clk); #1 bus.bready = 0;
        wr_txn(32'h0C, 32'h00000044, 4'h1, resp, pulse);
        check("s33_wr_bresp", 32'(resp), 32'(RESP_OKAY));
        check("s33_wr_pulse", 32'(pulse), 32'h08);
        rd_txn(32'h0C, data, resp);
        check("s33_rd", data, 32'h00000044);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
